// File: rtl/btn_pkg.sv
// Shared definitions for the button/switch input-conditioning blocks.
//   - btn_state_e : debounce FSM state encoding
//   - *_DEF       : default parameter values for btn_conditioner
package btn_pkg;

    typedef enum logic [1:0] {
        S_LOW    = 2'd0,
        S_WAIT_H = 2'd1,
        S_HIGH   = 2'd2,
        S_WAIT_L = 2'd3
    } btn_state_e;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int HOLD_CYCLES_DEF     = 16;

endpackage

// File: rtl/btn_conditioner_sync_chain.sv
// sync_chain: generic multi-flop synchroniser for an asynchronous single-bit input.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous, active-high reset (chain clears to 0)
//   d    in  asynchronous input
//   q    out d delayed by SYNC_STAGES rising edges of clk
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronises and debounces a raw bouncing input, then produces a clean level
// plus single-cycle rise/fall/hold pulses intended for the data inputs of downstream storage cells.
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous, active-high reset
//   din         in   raw asynchronous input, may bounce
//   level       out  debounced level (registered)
//   rise_pulse  out  one cycle high when level goes 0->1
//   fall_pulse  out  one cycle high when level goes 1->0
//   hold_pulse  out  one cycle high once level has stayed high HOLD_CYCLES cycles
//
// state    | meaning
// S_LOW    | accepted level 0, input agrees
// S_WAIT_H | accepted level 0, counting consecutive 1 samples
// S_HIGH   | accepted level 1, input agrees, hold counter running
// S_WAIT_L | accepted level 1, counting consecutive 0 samples, hold counter paused
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int CNT_W           = $clog2(((HOLD_CYCLES > DEBOUNCE_CYCLES) ?
                                            HOLD_CYCLES : DEBOUNCE_CYCLES) + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic hold_pulse
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_PRE = CNT_W'(HOLD_CYCLES - 1);

    logic s;

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             hold_q, hold_d;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (s)
    );

    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        level_d    = level_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        hold_d     = 1'b0;

        case (state_q)
            S_LOW: begin
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d    = S_HIGH;
                        level_d    = 1'b1;
                        rise_d     = 1'b1;
                        hold_cnt_d = '0;
                        deb_cnt_d  = '0;
                    end else begin
                        state_d   = S_WAIT_H;
                        deb_cnt_d = CNT_ONE;
                    end
                end
            end
            S_WAIT_H: begin
                if (!s) begin
                    state_d   = S_LOW;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d    = S_HIGH;
                    level_d    = 1'b1;
                    rise_d     = 1'b1;
                    hold_cnt_d = '0;
                    deb_cnt_d  = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d   = S_LOW;
                        level_d   = 1'b0;
                        fall_d    = 1'b1;
                        deb_cnt_d = '0;
                    end else begin
                        state_d   = S_WAIT_L;
                        deb_cnt_d = CNT_ONE;
                    end
                end
            end
            S_WAIT_L: begin
                // A return to S_HIGH keeps level and the hold count as they were.
                if (s) begin
                    state_d   = S_HIGH;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = S_LOW;
                    level_d   = 1'b0;
                    fall_d    = 1'b1;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d   = S_LOW;
                level_d   = 1'b0;
                deb_cnt_d = '0;
            end
        endcase

        // Hold counter advances only in S_HIGH and saturates, so the pulse fires once per press.
        if ((state_q == S_HIGH) && (state_d != S_LOW) && (hold_cnt_q != HOLD_MAX)) begin
            hold_cnt_d = hold_cnt_q + CNT_ONE;
            if (hold_cnt_q == HOLD_PRE) begin
                hold_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LOW;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            level_q    <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            hold_q     <= hold_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign hold_pulse = hold_q;

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic level, rise_pulse, fall_pulse, hold_pulse;
    logic t_q;

    int errors = 0;
    int checks = 0;
    string phase = "init";

    // Reference model: input delayed by SYNC edges; level flips after DEB consecutive
    // samples that disagree with it; hold counts edges spent high and agreeing.
    logic [SYNC-1:0] m_sh;
    logic m_level, m_tog;
    logic e_rise, e_fall, e_hold;
    int   m_run, m_hold;

    int dut_rises, dut_falls, dut_holds;
    int rise_at, hold_at;
    logic cur;
    int len;

    btn_conditioner dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .level      (level),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .hold_pulse (hold_pulse)
    );

    // Downstream toggle cell fed by rise_pulse on the same clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) t_q <= 1'b0;
        else if (rise_pulse) t_q <= ~t_q;
    end

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed=%0b expected=%0b", phase, tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed=%0d expected=%0d", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sh = '0; m_level = 1'b0; m_tog = 1'b0;
        e_rise = 1'b0; e_fall = 1'b0; e_hold = 1'b0;
        m_run = 0; m_hold = 0;
    endtask

    task automatic model_edge(input logic d);
        logic s_old;
        logic pre_high;
        if (e_rise) m_tog = ~m_tog;
        s_old = m_sh[SYNC-1];
        m_sh = {m_sh[SYNC-2:0], d};
        pre_high = m_level && (m_run == 0);
        e_rise = 1'b0; e_fall = 1'b0; e_hold = 1'b0;
        if (s_old != m_level) begin
            m_run++;
            if (m_run == DEB) begin
                m_run = 0;
                m_level = s_old;
                if (m_level) begin
                    e_rise = 1'b1;
                    m_hold = 0;
                end else begin
                    e_fall = 1'b1;
                end
            end
        end else begin
            m_run = 0;
        end
        if (pre_high && m_level && m_hold < HOLD) begin
            m_hold++;
            if (m_hold == HOLD) e_hold = 1'b1;
        end
    endtask

    task automatic step(input logic d);
        din = d;
        @(posedge clk);
        model_edge(d);
        #1;
        check("level", level, m_level);
        check("rise", rise_pulse, e_rise);
        check("fall", fall_pulse, e_fall);
        check("hold", hold_pulse, e_hold);
        check("t_ff", t_q, m_tog);
        if (rise_pulse) dut_rises++;
        if (fall_pulse) dut_falls++;
        if (hold_pulse) dut_holds++;
    endtask

    task automatic check_all_zero();
        check("rst_level", level, 1'b0);
        check("rst_rise", rise_pulse, 1'b0);
        check("rst_fall", fall_pulse, 1'b0);
        check("rst_hold", hold_pulse, 1'b0);
    endtask

    // Called 1 time unit after an edge: asserts rst between edges and checks it acts at once.
    task automatic async_reset();
        #3 rst = 1'b1;
        #1 check_all_zero();
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        check_all_zero();
    endtask

    initial begin
        model_reset();
        dut_rises = 0; dut_falls = 0; dut_holds = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        phase = "reset";
        check_all_zero();
        repeat (4) step(1'b0);

        // Clean press, held 40 cycles: one rise at SYNC+DEB-1 edges after the first, one hold.
        phase = "press";
        rise_at = 0; hold_at = 0; dut_holds = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1'b1);
            if (rise_pulse) rise_at = i;
            if (hold_pulse) hold_at = i;
        end
        check_int("rise_latency", rise_at, SYNC + DEB);
        check_int("hold_latency", hold_at, SYNC + DEB + HOLD);
        check_int("hold_once", dut_holds, 1);
        dut_falls = 0;
        repeat (12) step(1'b0);
        check_int("release_fall", dut_falls, 1);

        // Second press re-arms hold.
        phase = "repress";
        dut_rises = 0; dut_holds = 0;
        repeat (30) step(1'b1);
        check_int("rise2", dut_rises, 1);
        check_int("hold2", dut_holds, 1);
        repeat (12) step(1'b0);

        // Bounce on press: 1,1,1,0 then stable 1.
        phase = "bounce";
        dut_rises = 0; rise_at = 0;
        step(1'b1); step(1'b1); step(1'b1); step(1'b0);
        for (int i = 5; i <= 20; i++) begin
            step(1'b1);
            if (rise_pulse) rise_at = i;
        end
        check_int("bounce_rise_at", rise_at, 5 + SYNC + DEB - 1);
        check_int("bounce_rises", dut_rises, 1);

        // Release bounce: short 0 glitches do not drop level, later stable 0 gives one fall.
        phase = "rel_bounce";
        dut_rises = 0; dut_falls = 0;
        step(1'b0); step(1'b1); step(1'b0); step(1'b1);
        repeat (6) step(1'b1);
        check_int("glitch_falls", dut_falls, 0);
        check_int("glitch_rises", dut_rises, 0);
        repeat (12) step(1'b0);
        check_int("final_falls", dut_falls, 1);

        // Reset in S_WAIT_H.
        phase = "rst_wait";
        repeat (3) step(1'b1);
        async_reset();
        dut_rises = 0;
        repeat (10) step(1'b0);
        check_int("no_pulse_after_rst", dut_rises, 0);

        // Reset at hold count 10; din stays high so a fresh debounce follows.
        phase = "rst_hold";
        repeat (SYNC + DEB + 10) step(1'b1);
        async_reset();
        dut_rises = 0; dut_holds = 0; rise_at = 0;
        for (int i = 1; i <= 30; i++) begin
            step(1'b1);
            if (rise_pulse && rise_at == 0) rise_at = i;
        end
        check_int("fresh_rise_at", rise_at, SYNC + DEB);
        check_int("fresh_hold", dut_holds, 1);
        repeat (12) step(1'b0);

        // Random bouncy stimulus against the model.
        phase = "random";
        cur = 1'b0;
        for (int b = 0; b < 120; b++) begin
            cur = ~cur;
            if ($urandom_range(0, 3) == 0) len = $urandom_range(10, 30);
            else len = $urandom_range(1, 5);
            for (int j = 0; j < len; j++) step(cur);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
